// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the alu and its round-robin scheduler.
//   ALU_*          3-bit alu operation codes (110/111 are reserved, alu returns 0)
//   sched_state_e  scheduler FSM states
package alu_pkg;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_XNOR = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_RESP = 2'b10
  } sched_state_e;

endpackage

// File: rtl/alu.sv
// alu: combinational DATA_WIDTH-bit alu shared through alu_rr_sched.
//   input_1, input_2  operands
//   sel               operation (ALU_* codes; reserved codes give 0)
//   cin               carry-in for ADD, borrow-in for SUB
//   alu_out           result
//   overflow_flag     signed overflow for ADD/SUB, 0 otherwise
//   zero_flag         alu_out == 0
module alu
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] input_1,
  input  logic [DATA_WIDTH-1:0] input_2,
  input  logic [2:0]            sel,
  input  logic                  cin,
  output logic [DATA_WIDTH-1:0] alu_out,
  output logic                  overflow_flag,
  output logic                  zero_flag
);

  localparam int unsigned MSB = DATA_WIDTH - 1;

  always_comb begin
    alu_out       = '0;
    overflow_flag = 1'b0;
    case (sel)
      ALU_ADD: begin
        alu_out       = input_1 + input_2 + DATA_WIDTH'(cin);
        overflow_flag = (input_1[MSB] == input_2[MSB]) && (alu_out[MSB] != input_1[MSB]);
      end
      ALU_SUB: begin
        alu_out       = input_1 - input_2 - DATA_WIDTH'(cin);
        overflow_flag = (input_1[MSB] != input_2[MSB]) && (alu_out[MSB] != input_1[MSB]);
      end
      ALU_AND:  alu_out = input_1 & input_2;
      ALU_OR:   alu_out = input_1 | input_2;
      ALU_XOR:  alu_out = input_1 ^ input_2;
      ALU_XNOR: alu_out = ~(input_1 ^ input_2);
      default:  alu_out = '0;
    endcase
  end

  assign zero_flag = (alu_out == '0);

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req_i          request vector
//   last_grant_i   index granted most recently; search starts just after it
//   grant_o        one-hot grant
//   grant_idx_o    index of the granted requester
//   grant_valid_o  at least one request was present
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_grant_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   grant_idx_o,
  output logic               grant_valid_o
);

  logic found;

  // Walk offsets 1..NUM_REQ from last_grant_i; the first requesting slot wins,
  // so last_grant_i itself has the lowest priority.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!found && req_i[j] && (j == (32'(last_grant_i) + off) % NUM_REQ)) begin
          grant_o[j]  = 1'b1;
          grant_idx_o = j[IDX_W-1:0];
          found       = 1'b1;
        end
      end
    end
  end

  assign grant_valid_o = found;

endmodule

// File: rtl/alu_rr_sched.sv
// alu_rr_sched: shares one external combinational alu between NUM_REQ
// requesters with round-robin arbitration and valid/ready handshakes.
//   clk, rst                        clock, synchronous active-high reset
//   req_valid/req_ready             request handshake (ready one-hot, IDLE only)
//   req_sel/req_a/req_b/req_cin     packed per-requester operation and operands
//   rsp_valid/rsp_ready             response handshake (valid one-hot to grantee)
//   rsp_data/rsp_overflow/rsp_zero  registered alu result and flags
//   alu_input_1/2, alu_sel, alu_cin driven from the operand registers
//   alu_out/alu_overflow/alu_zero   returned by the alu
//   busy                            high outside IDLE
module alu_rr_sched
  import alu_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [3*NUM_REQ-1:0]          req_sel,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] req_a,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] req_b,
  input  logic [NUM_REQ-1:0]            req_cin,
  output logic [NUM_REQ-1:0]            rsp_valid,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_overflow,
  output logic                          rsp_zero,
  output logic [DATA_WIDTH-1:0]         alu_input_1,
  output logic [DATA_WIDTH-1:0]         alu_input_2,
  output logic [2:0]                    alu_sel,
  output logic                          alu_cin,
  input  logic [DATA_WIDTH-1:0]         alu_out,
  input  logic                          alu_overflow,
  input  logic                          alu_zero,
  output logic                          busy
);

  localparam int unsigned IDX_W = (NUM_REQ > 2) ? 2 : 1;

  sched_state_e state_q, state_d;

  logic [IDX_W-1:0]      last_grant_q, last_grant_d;
  logic [IDX_W-1:0]      grant_q, grant_d;
  logic [2:0]            op_sel_q, op_sel_d;
  logic [DATA_WIDTH-1:0] op_a_q, op_a_d;
  logic [DATA_WIDTH-1:0] op_b_q, op_b_d;
  logic                  op_cin_q, op_cin_d;
  logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
  logic                  res_ovf_q, res_ovf_d;
  logic                  res_zero_q, res_zero_d;

  logic [NUM_REQ-1:0]    arb_grant;
  logic [IDX_W-1:0]      arb_idx;
  logic                  arb_valid;

  logic [2:0]            cand_sel;
  logic [DATA_WIDTH-1:0] cand_a;
  logic [DATA_WIDTH-1:0] cand_b;
  logic                  cand_cin;
  logic                  rsp_accept;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req_i         (req_valid),
    .last_grant_i  (last_grant_q),
    .grant_o       (arb_grant),
    .grant_idx_o   (arb_idx),
    .grant_valid_o (arb_valid)
  );

  // Operands of the requester the arbiter currently picks.
  always_comb begin
    cand_sel = '0;
    cand_a   = '0;
    cand_b   = '0;
    cand_cin = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == i[IDX_W-1:0]) begin
        cand_sel = req_sel[3*i +: 3];
        cand_a   = req_a[DATA_WIDTH*i +: DATA_WIDTH];
        cand_b   = req_b[DATA_WIDTH*i +: DATA_WIDTH];
        cand_cin = req_cin[i];
      end
    end
  end

  // Only the stored grantee's rsp_ready can close the response.
  always_comb begin
    rsp_accept = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_q == i[IDX_W-1:0]) rsp_accept = rsp_ready[i];
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (arb_valid) state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (rsp_accept) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    req_ready = (state_q == S_IDLE) ? arb_grant : '0;
    rsp_valid = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (state_q == S_RESP && grant_q == i[IDX_W-1:0]) rsp_valid[i] = 1'b1;
    end
    busy = (state_q != S_IDLE);
  end

  // Datapath next state: operands only load at the accept edge, results only
  // at the EXEC edge, so both stay frozen while the response waits.
  always_comb begin
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    op_sel_d     = op_sel_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_cin_d     = op_cin_q;
    res_data_d   = res_data_q;
    res_ovf_d    = res_ovf_q;
    res_zero_d   = res_zero_q;
    case (state_q)
      S_IDLE: begin
        if (arb_valid) begin
          grant_d  = arb_idx;
          op_sel_d = cand_sel;
          op_a_d   = cand_a;
          op_b_d   = cand_b;
          op_cin_d = cand_cin;
        end
      end
      S_EXEC: begin
        res_data_d = alu_out;
        res_ovf_d  = alu_overflow;
        res_zero_d = alu_zero;
      end
      S_RESP: begin
        if (rsp_accept) last_grant_d = grant_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      grant_q      <= '0;
      op_sel_q     <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_cin_q     <= 1'b0;
      res_data_q   <= '0;
      res_ovf_q    <= 1'b0;
      res_zero_q   <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      op_sel_q     <= op_sel_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_cin_q     <= op_cin_d;
      res_data_q   <= res_data_d;
      res_ovf_q    <= res_ovf_d;
      res_zero_q   <= res_zero_d;
    end
  end

  assign alu_input_1  = op_a_q;
  assign alu_input_2  = op_b_q;
  assign alu_sel      = op_sel_q;
  assign alu_cin      = op_cin_q;
  assign rsp_data     = res_data_q;
  assign rsp_overflow = res_ovf_q;
  assign rsp_zero     = res_zero_q;

endmodule
